// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with configurable width/depth, almost-full/empty thresholds
// and a selectable registered or first-word-fall-through read port.
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CW-1:0]         count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [FIFO_WIDTH-1:0] dout_q;
    logic                  rd_acc, wr_acc;

    // A write into a full FIFO is still legal when the same edge frees a slot.
    assign rd_acc = rd_en && (count != '0);
    assign wr_acc = wr_en && (!full || rd_acc);

    assign full        = (count == DEPTH_C);
    assign empty       = (count == '0);
    assign almostfull  = (count >= AF_C) && (count < DEPTH_C);
    assign almostempty = (count != '0) && (count <= AE_C);

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dout_q    <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= nxt(wr_ptr);
            if (rd_acc) begin
                rd_ptr <= nxt(rd_ptr);
                dout_q <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            wr_ack    <= wr_acc;
            overflow  <= wr_en && !wr_acc;
            underflow <= rd_en && !rd_acc;
        end
    end

    // Storage has no reset; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) mem[wr_ptr] <= data_in;
    end

    // In FWFT mode dout_q holds the last popped word, shown only while empty.
    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? dout_q : mem[rd_ptr];
        end else begin : g_std
            assign data_out = dout_q;
        end
    endgenerate
endmodule
